// File: rtl/hq2x_pkg.sv
// Shared types and constants for the Hq2x timing scheduler.
package hq2x_pkg;

   localparam int BURST_LEN = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PH1  = 2'd1,
      PH2  = 2'd2,
      PH3  = 2'd3
   } phase_t;

   localparam phase_t LAST_PH = phase_t'(2'(BURST_LEN - 1));

   function automatic int cnt_width(input int length);
      return $clog2(length) + 1;
   endfunction

endpackage

// File: rtl/hq2x_line_meas.sv
// Source line measurement: counts accepted strobes per line and flags the
// line start and half-line points that pace the doubled output rows.
module hq2x_line_meas #(
   parameter int CW = 11
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          accept,
   input  logic          hblank_in,
   output logic          line_start,
   output logic          half_line,
   output logic [CW-1:0] total_nxt,
   output logic [CW-1:0] active_nxt,
   output logic [CW-1:0] line_total,
   output logic [CW-1:0] line_active
);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] pix_cnt;
   logic [CW-1:0] act_cnt;
   logic          prev_hblank;

   assign line_start = accept && !hblank_in && prev_hblank;
   // Compared with the strobes already counted, so it lands on the strobe after the midpoint.
   assign half_line  = accept && !line_start && (line_total != '0) &&
                       (pix_cnt == (line_total >> 1));
   assign total_nxt  = line_start ? pix_cnt : line_total;
   assign active_nxt = line_start ? act_cnt : line_active;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_cnt     <= '0;
         act_cnt     <= '0;
         line_total  <= '0;
         line_active <= '0;
         prev_hblank <= 1'b1;
      end else if (accept) begin
         prev_hblank <= hblank_in;
         line_total  <= total_nxt;
         line_active <= active_nxt;
         if (line_start) begin
            pix_cnt <= CW'(1);
            act_cnt <= CW'(1);
         end else begin
            if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
            if (!hblank_in && act_cnt != CNT_MAX) act_cnt <= act_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hq2x_sched.sv
// Hq2x timing scheduler: expands each source strobe into a 4-clock burst and
// drives line/frame resets, output row select and output blanking.
module hq2x_sched
   import hq2x_pkg::*;
#(
   parameter int LENGTH = 1024,
   parameter int DWIDTH = 23
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            enable,
   input  logic            ce_pix,
   input  logic [DWIDTH:0] pix_in,
   input  logic            hblank_in,
   input  logic            vblank_in,
   output logic            ce_in,
   output logic [DWIDTH:0] pix_out,
   output logic            reset_line,
   output logic            reset_frame,
   output logic            ce_out,
   output logic [1:0]      read_y,
   output logic            hblank_out,
   output logic            overrun
);
   localparam int CW = cnt_width(LENGTH);
   localparam logic [CW:0] OUT_MAX = '1;

   phase_t        state;
   phase_t        state_nxt;
   logic          accept;
   logic          line_start;
   logic          half_line;
   logic [CW-1:0] total_nxt;
   logic [CW-1:0] active_nxt;
   logic [CW-1:0] line_total;
   logic [CW-1:0] line_active;
   logic [CW:0]   out_px;
   logic [CW:0]   out_px_nxt;
   logic          wbuf;
   logic          vblank_end;

   assign accept     = enable && (state == IDLE) && ce_pix;
   assign ce_out     = ce_in;
   // reset_frame holds the vblank level of the previous accepted strobe.
   assign vblank_end = reset_frame && !vblank_in;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      ce_in     = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (ce_pix) begin
                  ce_in     = 1'b1;
                  state_nxt = PH1;
               end
            end
            default: begin
               ce_in     = 1'b1;
               state_nxt = (state == LAST_PH) ? IDLE : phase_t'(state + 2'd1);
            end
         endcase
      end
   end

   always_comb begin
      out_px_nxt = out_px;
      if (line_start || half_line) out_px_nxt = '0;
      else if (ce_out && out_px != OUT_MAX) out_px_nxt = out_px + 1'b1;
   end

   hq2x_line_meas #(.CW(CW)) u_meas (
      .clk         (clk),
      .reset_n     (reset_n),
      .accept      (accept),
      .hblank_in   (hblank_in),
      .line_start  (line_start),
      .half_line   (half_line),
      .total_nxt   (total_nxt),
      .active_nxt  (active_nxt),
      .line_total  (line_total),
      .line_active (line_active)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         pix_out     <= '0;
         reset_line  <= 1'b1;
         reset_frame <= 1'b1;
         read_y      <= 2'b00;
         wbuf        <= 1'b0;
         out_px      <= '0;
         hblank_out  <= 1'b1;
         overrun     <= 1'b0;
      end else begin
         state  <= state_nxt;
         out_px <= out_px_nxt;
         if (enable && state != IDLE && ce_pix) overrun <= 1'b1;
         if (!enable) begin
            reset_line <= 1'b1;
            hblank_out <= 1'b1;
         end else begin
            // Built from next-state values so the flag lines up with the out_px it describes.
            hblank_out <= (total_nxt == '0) || (out_px_nxt >= {active_nxt, 1'b0});
            if (accept) begin
               pix_out     <= pix_in;
               reset_line  <= hblank_in;
               reset_frame <= vblank_in;
            end
         end
         if (line_start) begin
            read_y[0] <= 1'b0;
            read_y[1] <= wbuf;
            wbuf      <= vblank_end ? 1'b0 : ~wbuf;
         end else if (half_line) begin
            read_y[0] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hq2x_sched.sv
// Directed bench for hq2x_sched: bursts, overrun, line measurement, parity,
// enable gating and asynchronous reset.
module tb_hq2x_sched;
   localparam int DWIDTH = 23;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic            ce_pix;
   logic [DWIDTH:0] pix_in;
   logic            hblank_in;
   logic            vblank_in;
   logic            ce_in;
   logic [DWIDTH:0] pix_out;
   logic            reset_line;
   logic            reset_frame;
   logic            ce_out;
   logic [1:0]      read_y;
   logic            hblank_out;
   logic            overrun;

   int n_checks = 0;
   int n_errors = 0;
   int n_ce_in = 0;
   int n_ce_out = 0;
   int n_vis = 0;
   int run = 0;
   int last_run = 0;

   hq2x_sched #(.LENGTH(1024), .DWIDTH(DWIDTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .ce_pix      (ce_pix),
      .pix_in      (pix_in),
      .hblank_in   (hblank_in),
      .vblank_in   (vblank_in),
      .ce_in       (ce_in),
      .pix_out     (pix_out),
      .reset_line  (reset_line),
      .reset_frame (reset_frame),
      .ce_out      (ce_out),
      .read_y      (read_y),
      .hblank_out  (hblank_out),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   // One clock: strobe applied just after the edge, outputs sampled mid-cycle.
   task automatic cyc(input logic cp);
      @(posedge clk);
      #1;
      ce_pix = cp;
      #1;
      if (ce_in === 1'b1) begin
         n_ce_in++;
         run++;
      end else if (run != 0) begin
         last_run = run;
         run = 0;
      end
      if (ce_out === 1'b1) n_ce_out++;
      if (ce_out === 1'b1 && hblank_out === 1'b0) n_vis++;
   endtask

   task automatic send_pix(input logic hb, input logic vb, input logic [DWIDTH:0] d);
      hblank_in = hb;
      vblank_in = vb;
      pix_in    = d;
      cyc(1'b1);
      repeat (7) cyc(1'b0);
   endtask

   task automatic send_run(input int n, input logic hb, input logic vb);
      for (int i = 0; i < n; i++) send_pix(hb, vb, 24'(i * 7 + 1));
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; ce_pix = 1'b0;
      pix_in = '0; hblank_in = 1'b1; vblank_in = 1'b1;
      repeat (3) cyc(1'b0);
      n_checks++; if (ce_in !== 1'b0) begin n_errors++; $display("FAIL rst_ce_in: got %b want 0", ce_in); end
      n_checks++; if (ce_out !== 1'b0) begin n_errors++; $display("FAIL rst_ce_out: got %b want 0", ce_out); end
      n_checks++; if (pix_out !== 24'h0) begin n_errors++; $display("FAIL rst_pix_out: got %h want 0", pix_out); end
      n_checks++; if (read_y !== 2'b00) begin n_errors++; $display("FAIL rst_read_y: got %b want 00", read_y); end
      n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      n_checks++; if (reset_line !== 1'b1) begin n_errors++; $display("FAIL rst_reset_line: got %b want 1", reset_line); end
      n_checks++; if (reset_frame !== 1'b1) begin n_errors++; $display("FAIL rst_reset_frame: got %b want 1", reset_frame); end
      n_checks++; if (hblank_out !== 1'b1) begin n_errors++; $display("FAIL rst_hblank_out: got %b want 1", hblank_out); end
      n_checks++; if (dut.line_total !== 11'd0) begin n_errors++; $display("FAIL rst_line_total: got %0d want 0", dut.line_total); end
      reset_n = 1'b1;
      enable = 1'b1;
      repeat (2) cyc(1'b0);
   endtask

   task automatic test_burst();
      logic [DWIDTH:0] vals [3];
      int c0, o0;
      vals[0] = 24'h123456; vals[1] = 24'hABCDEF; vals[2] = 24'h000001;
      for (int i = 0; i < 3; i++) begin
         c0 = n_ce_in; o0 = n_ce_out;
         send_pix(1'b1, 1'b1, vals[i]);
         n_checks++; if (n_ce_in - c0 !== 4) begin n_errors++; $display("FAIL burst_ce_in[%0d]: got %0d want 4", i, n_ce_in - c0); end
         n_checks++; if (n_ce_out - o0 !== 4) begin n_errors++; $display("FAIL burst_ce_out[%0d]: got %0d want 4", i, n_ce_out - o0); end
         n_checks++; if (last_run !== 4) begin n_errors++; $display("FAIL burst_run[%0d]: got %0d want 4", i, last_run); end
         n_checks++; if (pix_out !== vals[i]) begin n_errors++; $display("FAIL burst_pix_out[%0d]: got %h want %h", i, pix_out, vals[i]); end
      end
      n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL burst_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_overrun();
      int c0;
      hblank_in = 1'b1; vblank_in = 1'b1; pix_in = 24'h0F0F0F;
      c0 = n_ce_in;
      cyc(1'b1);
      cyc(1'b0);
      pix_in = 24'h707070;
      cyc(1'b1);
      repeat (9) cyc(1'b0);
      n_checks++; if (n_ce_in - c0 !== 4) begin n_errors++; $display("FAIL ovr_ce_in: got %0d want 4", n_ce_in - c0); end
      n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      n_checks++; if (pix_out !== 24'h0F0F0F) begin n_errors++; $display("FAIL ovr_pix_out: got %h want 0f0f0f", pix_out); end
      send_pix(1'b1, 1'b1, 24'h55AA55);
      n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
      n_checks++; if (pix_out !== 24'h55AA55) begin n_errors++; $display("FAIL ovr_next_pix: got %h want 55aa55", pix_out); end
   endtask

   task automatic test_line_measure();
      int v;
      // Line A: measured only; previous line had no active pixels so it stays blank.
      v = n_vis;
      send_run(320, 1'b0, 1'b0);
      send_run(80, 1'b1, 1'b0);
      n_checks++; if (n_vis - v !== 0) begin n_errors++; $display("FAIL lineA_visible: got %0d want 0", n_vis - v); end
      // Line B
      n_vis = 0;
      send_pix(1'b0, 1'b0, 24'h000100);
      n_checks++; if (dut.line_total !== 11'd400) begin n_errors++; $display("FAIL line_total: got %0d want 400", dut.line_total); end
      n_checks++; if (dut.line_active !== 11'd320) begin n_errors++; $display("FAIL line_active: got %0d want 320", dut.line_active); end
      n_checks++; if (read_y !== 2'b00) begin n_errors++; $display("FAIL lineB_read_y: got %b want 00", read_y); end
      n_checks++; if (reset_line !== 1'b0) begin n_errors++; $display("FAIL lineB_reset_line: got %b want 0", reset_line); end
      send_run(199, 1'b0, 1'b0);
      n_checks++; if (read_y[0] !== 1'b0) begin n_errors++; $display("FAIL pre_half_read_y0: got %b want 0", read_y[0]); end
      n_checks++; if (n_vis !== 640) begin n_errors++; $display("FAIL first_half_visible: got %0d want 640", n_vis); end
      n_vis = 0;
      send_pix(1'b0, 1'b0, 24'h000200);
      n_checks++; if (read_y[0] !== 1'b1) begin n_errors++; $display("FAIL half_read_y0: got %b want 1", read_y[0]); end
      send_run(119, 1'b0, 1'b0);
      send_run(80, 1'b1, 1'b0);
      n_checks++; if (n_vis !== 640) begin n_errors++; $display("FAIL second_half_visible: got %0d want 640", n_vis); end
      // Line C start
      send_pix(1'b0, 1'b0, 24'h000300);
      n_checks++; if (read_y !== 2'b10) begin n_errors++; $display("FAIL lineC_read_y: got %b want 10", read_y); end
      n_checks++; if (dut.line_total !== 11'd400) begin n_errors++; $display("FAIL lineC_total: got %0d want 400", dut.line_total); end
   endtask

   task automatic test_parity();
      logic exp_ry1 [4];
      exp_ry1[0] = 1'b0; exp_ry1[1] = 1'b0; exp_ry1[2] = 1'b1; exp_ry1[3] = 1'b0;
      send_pix(1'b0, 1'b0, 24'h1);
      send_run(2, 1'b1, 1'b0);
      n_checks++; if (reset_line !== 1'b1) begin n_errors++; $display("FAIL par_blank_reset_line: got %b want 1", reset_line); end
      // Two lines inside vertical blank.
      send_pix(1'b0, 1'b1, 24'h2);
      n_checks++; if (read_y[1] !== 1'b0) begin n_errors++; $display("FAIL par_v1_read_y1: got %b want 0", read_y[1]); end
      n_checks++; if (reset_frame !== 1'b1) begin n_errors++; $display("FAIL par_v1_reset_frame: got %b want 1", reset_frame); end
      n_checks++; if (reset_line !== 1'b0) begin n_errors++; $display("FAIL par_v1_reset_line: got %b want 0", reset_line); end
      send_pix(1'b0, 1'b1, 24'h3);
      send_run(2, 1'b1, 1'b1);
      send_pix(1'b0, 1'b1, 24'h4);
      n_checks++; if (read_y[1] !== 1'b1) begin n_errors++; $display("FAIL par_v2_read_y1: got %b want 1", read_y[1]); end
      send_pix(1'b0, 1'b1, 24'h5);
      send_run(2, 1'b1, 1'b1);
      // First four lines after vertical blank ends.
      for (int i = 0; i < 4; i++) begin
         send_pix(1'b0, 1'b0, 24'(16 + i));
         n_checks++; if (read_y[1] !== exp_ry1[i]) begin n_errors++; $display("FAIL par_line%0d_read_y1: got %b want %b", i, read_y[1], exp_ry1[i]); end
         if (i == 0) begin
            n_checks++; if (reset_frame !== 1'b0) begin n_errors++; $display("FAIL par_reset_frame: got %b want 0", reset_frame); end
         end
         send_pix(1'b0, 1'b0, 24'(32 + i));
         send_run(2, 1'b1, 1'b0);
      end
   endtask

   task automatic test_enable();
      int c0;
      hblank_in = 1'b0; vblank_in = 1'b0; pix_in = 24'h3C3C3C;
      cyc(1'b1);
      cyc(1'b0);
      enable = 1'b0;
      #1;
      n_checks++; if (ce_in !== 1'b0) begin n_errors++; $display("FAIL en_ce_in: got %b want 0", ce_in); end
      n_checks++; if (ce_out !== 1'b0) begin n_errors++; $display("FAIL en_ce_out: got %b want 0", ce_out); end
      cyc(1'b0);
      n_checks++; if (reset_line !== 1'b1) begin n_errors++; $display("FAIL en_reset_line: got %b want 1", reset_line); end
      n_checks++; if (hblank_out !== 1'b1) begin n_errors++; $display("FAIL en_hblank_out: got %b want 1", hblank_out); end
      pix_in = 24'h111111;
      c0 = n_ce_in;
      cyc(1'b1);
      repeat (2) cyc(1'b0);
      n_checks++; if (pix_out !== 24'h3C3C3C) begin n_errors++; $display("FAIL en_pix_hold: got %h want 3c3c3c", pix_out); end
      n_checks++; if (dut.line_total !== 11'd4) begin n_errors++; $display("FAIL en_total_hold: got %0d want 4", dut.line_total); end
      enable = 1'b1;
      repeat (3) cyc(1'b0);
      n_checks++; if (n_ce_in - c0 !== 0) begin n_errors++; $display("FAIL en_no_resume: got %0d want 0", n_ce_in - c0); end
      c0 = n_ce_in;
      send_pix(1'b1, 1'b0, 24'h777777);
      n_checks++; if (n_ce_in - c0 !== 4) begin n_errors++; $display("FAIL en_resume_burst: got %0d want 4", n_ce_in - c0); end
      n_checks++; if (pix_out !== 24'h777777) begin n_errors++; $display("FAIL en_resume_pix: got %h want 777777", pix_out); end
   endtask

   task automatic test_reset_mid();
      int c0, v;
      hblank_in = 1'b0; vblank_in = 1'b0; pix_in = 24'h9A9A9A;
      cyc(1'b1);
      cyc(1'b0);
      reset_n = 1'b0;
      #1;
      n_checks++; if (ce_in !== 1'b0) begin n_errors++; $display("FAIL mid_ce_in: got %b want 0", ce_in); end
      n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL mid_overrun: got %b want 0", overrun); end
      n_checks++; if (reset_line !== 1'b1) begin n_errors++; $display("FAIL mid_reset_line: got %b want 1", reset_line); end
      n_checks++; if (reset_frame !== 1'b1) begin n_errors++; $display("FAIL mid_reset_frame: got %b want 1", reset_frame); end
      n_checks++; if (pix_out !== 24'h0) begin n_errors++; $display("FAIL mid_pix_out: got %h want 0", pix_out); end
      n_checks++; if (read_y !== 2'b00) begin n_errors++; $display("FAIL mid_read_y: got %b want 00", read_y); end
      n_checks++; if (hblank_out !== 1'b1) begin n_errors++; $display("FAIL mid_hblank_out: got %b want 1", hblank_out); end
      c0 = n_ce_in;
      repeat (2) cyc(1'b0);
      n_checks++; if (n_ce_in - c0 !== 0) begin n_errors++; $display("FAIL mid_no_partial: got %0d want 0", n_ce_in - c0); end
      reset_n = 1'b1;
      v = n_vis;
      send_run(8, 1'b0, 1'b0);
      send_run(2, 1'b1, 1'b0);
      n_checks++; if (n_vis - v !== 0) begin n_errors++; $display("FAIL post_rst_visible: got %0d want 0", n_vis - v); end
      n_checks++; if (dut.line_total !== 11'd0) begin n_errors++; $display("FAIL post_rst_total: got %0d want 0", dut.line_total); end
      n_vis = 0;
      send_pix(1'b0, 1'b0, 24'h000042);
      n_checks++; if (dut.line_total !== 11'd10) begin n_errors++; $display("FAIL short_total: got %0d want 10", dut.line_total); end
      n_checks++; if (dut.line_active !== 11'd8) begin n_errors++; $display("FAIL short_active: got %0d want 8", dut.line_active); end
      send_run(4, 1'b0, 1'b0);
      n_checks++; if (n_vis !== 16) begin n_errors++; $display("FAIL short_visible: got %0d want 16", n_vis); end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_overrun();
      test_line_measure();
      test_parity();
      test_enable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
